// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream packer.
// Holds the flush-state encoding and the lane-count width function.
// No logic; no latency and no backpressure of its own.
package fifo_stream_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } flush_state_t;

    function automatic int lane_cnt_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready holding register for one packed output beat.
// Latency: a load at edge N shows out_valid after edge N.
// Backpressure: data and lanes are held while out_valid && !out_ready; load only when out_free.
module stream_out_reg #(
    parameter int DW = 32,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [LW-1:0] load_lanes,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [LW-1:0] out_lanes,
    output logic          out_free
);

    assign out_free = !out_valid || out_ready;

    // A transfer and a load in the same cycle keep out_valid asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lanes <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_lanes <= load_lanes;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_stream_packer.sv
// Pops narrow FIFO words and packs RATIO of them (first word in lane 0) into one wide beat.
// Latency: last word popped at edge N gives out_valid after edge N; flush sampled at N loads at N+1.
// Backpressure: with a beat held, up to RATIO-1 more words accumulate, then popping stalls.
// Partial-beat flush is built only with FIFO_STREAM_PACKER_FLUSH_EN defined.
module fifo_stream_packer
    import fifo_stream_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int RATIO     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           fifo_rd,
    input  logic [DATAWIDTH-1:0]           fifo_data,
    input  logic                           fifo_empty,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATAWIDTH*RATIO-1:0]     out_data,
    output logic [lane_cnt_w(RATIO)-1:0]   out_lanes,
    output logic                           busy
);

    localparam int LW = lane_cnt_w(RATIO);
    localparam int CW = $clog2(RATIO);
    localparam int AW = DATAWIDTH * (RATIO - 1);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0]              lane_cnt;
    logic [AW-1:0]              acc;
    logic                       out_free;
    logic                       flush_pending;
    logic                       load_full;
    logic                       load_part;
    logic                       load;
    logic [DATAWIDTH*RATIO-1:0] load_data;
    logic [LW-1:0]              load_lanes;

    // The final lane may only be popped when the output register can take the beat.
    assign fifo_rd   = !reset && !fifo_empty && !flush_pending &&
                       ((lane_cnt != LAST) || out_free);
    assign load_full = fifo_rd && (lane_cnt == LAST);

`ifdef FIFO_STREAM_PACKER_FLUSH_EN
    flush_state_t       flush_st;
    flush_state_t       flush_nxt;
    logic [AW-1:0]      part_data;

    always_ff @(posedge clk) begin
        if (reset) flush_st <= IDLE;
        else       flush_st <= flush_nxt;
    end

    always_comb begin
        flush_nxt = flush_st;
        load_part = 1'b0;
        case (flush_st)
            IDLE:    if (flush) flush_nxt = PENDING;
            PENDING: if (out_free) begin
                flush_nxt = IDLE;
                load_part = (lane_cnt != '0);
            end
            default: flush_nxt = IDLE;
        endcase
    end

    // Lanes at or above lane_cnt hold stale words from earlier beats; zero them.
    always_comb begin
        part_data = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (CW'(i) < lane_cnt)
                part_data[i*DATAWIDTH +: DATAWIDTH] = acc[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    assign flush_pending = (flush_st == PENDING);
    assign load          = load_full || load_part;
    assign load_data     = load_full ? {fifo_data, acc} : {{DATAWIDTH{1'b0}}, part_data};
    assign load_lanes    = load_full ? LW'(RATIO) : LW'(lane_cnt);
`else
    logic unused_flush;

    assign unused_flush  = flush;
    assign flush_pending = 1'b0;
    assign load_part     = 1'b0;
    assign load          = load_full;
    assign load_data     = {fifo_data, acc};
    assign load_lanes    = LW'(RATIO);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_cnt <= '0;
            acc      <= '0;
        end else if (fifo_rd) begin
            if (lane_cnt == LAST) begin
                lane_cnt <= '0;
            end else begin
                acc[lane_cnt*DATAWIDTH +: DATAWIDTH] <= fifo_data;
                lane_cnt <= lane_cnt + CW'(1);
            end
        end else if (load_part) begin
            lane_cnt <= '0;
        end
    end

    stream_out_reg #(
        .DW (DATAWIDTH * RATIO),
        .LW (LW)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .load_lanes (load_lanes),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_lanes  (out_lanes),
        .out_free   (out_free)
    );

    assign busy = (lane_cnt != '0) || out_valid || flush_pending;

endmodule
